// File: rtl/sump_cmd_sequencer.sv
// sump_cmd_sequencer: frames UART bytes into SUMP short/long commands, holds capture
// configuration registers and issues single-cycle command pulses.
module sump_cmd_sequencer #(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [23:0] DIV_RESET      = 24'h0,
    parameter logic [15:0] READ_RESET     = 16'h0,
    parameter logic [15:0] DELAY_RESET    = 16'h0
) (
    input  logic        system_clock,
    input  logic        ext_reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        capture_busy,
    output logic [23:0] sample_div,
    output logic [15:0] read_count,
    output logic [15:0] delay_count,
    output logic [7:0]  trig_rise_mask,
    output logic [7:0]  trig_fall_mask,
    output logic        cfg_update,
    output logic        arm_pulse,
    output logic        soft_reset_pulse,
    output logic        id_req,
    output logic        meta_req,
    output logic        cmd_error
);
    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [7:0]    r_op, r_b1, r_b2, r_b3;
    logic [TW-1:0] r_timer;
    logic          w_short, w_done, w_known, w_exec, w_short_ok;

    assign w_short    = r_state == IDLE && rx_valid && !rx_data[7];
    assign w_done     = r_state == COLLECT && rx_valid && r_cnt == 2'd3;
    assign w_known    = r_op == 8'h80 || r_op == 8'h81 || r_op == 8'hC1;
    assign w_exec     = w_done && w_known && !capture_busy;
    assign w_short_ok = rx_data == 8'h00 || rx_data == 8'h02 || rx_data == 8'h04 ||
                        (rx_data == 8'h01 && !capture_busy);

    // The 4th payload byte is used straight from rx_data, so only b1..b3 are stored.
    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_op             <= '0;
            r_b1             <= '0;
            r_b2             <= '0;
            r_b3             <= '0;
            r_timer          <= '0;
            sample_div       <= DIV_RESET;
            read_count       <= READ_RESET;
            delay_count      <= DELAY_RESET;
            trig_rise_mask   <= '0;
            trig_fall_mask   <= '0;
            cfg_update       <= 1'b0;
            arm_pulse        <= 1'b0;
            soft_reset_pulse <= 1'b0;
            id_req           <= 1'b0;
            meta_req         <= 1'b0;
            cmd_error        <= 1'b0;
        end else begin
            soft_reset_pulse <= w_short && rx_data == 8'h00;
            arm_pulse        <= w_short && rx_data == 8'h01 && !capture_busy;
            id_req           <= w_short && rx_data == 8'h02;
            meta_req         <= w_short && rx_data == 8'h04;
            cmd_error        <= (w_short && !w_short_ok) || (w_done && !(w_known && !capture_busy));
            cfg_update       <= w_exec;
            if (w_exec && r_op == 8'h80)
                sample_div <= {r_b2, r_b3, rx_data};
            if (w_exec && r_op == 8'h81) begin
                read_count  <= {r_b1, r_b2};
                delay_count <= {r_b3, rx_data};
            end
            if (w_exec && r_op == 8'hC1) begin
                trig_fall_mask <= r_b3;
                trig_rise_mask <= rx_data;
            end
            if (r_state == IDLE) begin
                r_timer <= '0;
                r_cnt   <= '0;
                if (rx_valid && rx_data[7]) begin
                    r_op    <= rx_data;
                    r_state <= COLLECT;
                end
            end else if (rx_valid) begin
                r_timer <= '0;
                r_cnt   <= r_cnt + 2'd1;
                if (r_cnt == 2'd0) r_b1 <= rx_data;
                if (r_cnt == 2'd1) r_b2 <= rx_data;
                if (r_cnt == 2'd2) r_b3 <= rx_data;
                if (r_cnt == 2'd3) r_state <= IDLE;
            end else if (r_timer == T_LAST) begin
                r_state <= IDLE;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sump_cmd_sequencer.sv
// tb_sump_cmd_sequencer: scoreboard bench; a byte-queue reference model predicts every
// pulse and the configuration snapshot that must accompany it.
module tb_sump_cmd_sequencer;
    localparam int TO = 64;

    logic        clk = 0, ext_reset_n = 0, rx_valid = 0, busy = 0;
    logic [7:0]  rx_data = 0;
    logic [23:0] sample_div;
    logic [15:0] read_count, delay_count;
    logic [7:0]  trig_rise_mask, trig_fall_mask;
    logic        cfg_update, arm_pulse, soft_reset_pulse, id_req, meta_req, cmd_error;

    sump_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .system_clock(clk), .ext_reset_n(ext_reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .capture_busy(busy), .sample_div(sample_div), .read_count(read_count),
        .delay_count(delay_count), .trig_rise_mask(trig_rise_mask),
        .trig_fall_mask(trig_fall_mask), .cfg_update(cfg_update), .arm_pulse(arm_pulse),
        .soft_reset_pulse(soft_reset_pulse), .id_req(id_req), .meta_req(meta_req),
        .cmd_error(cmd_error));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse vector order: {cfg_update, arm, soft_reset, id, meta, error}
    typedef struct {
        int          due;
        logic [5:0]  p;
        logic [23:0] div;
        logic [15:0] rd, dl;
        logic [7:0]  rm, fm;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  pend[$];
    int          last_edge = 0;
    logic [23:0] m_div = 0;
    logic [15:0] m_rd = 0, m_dl = 0;
    logic [7:0]  m_rm = 0, m_fm = 0;
    int          tests = 0, fails = 0;

    // Reference model: a command is whatever bytes have piled up; 5 of them make a long one.
    function automatic void model(logic [7:0] b, logic bz, int e);
        exp_t x;
        logic [5:0] p = 6'b0;
        if (pend.size() > 0 && e - last_edge > TO) pend.delete();
        last_edge = e;
        if (pend.size() == 0 && !b[7]) begin
            if (b == 8'h00) p = 6'b001000;
            else if (b == 8'h01) p = bz ? 6'b000001 : 6'b010000;
            else if (b == 8'h02) p = 6'b000100;
            else if (b == 8'h04) p = 6'b000010;
            else p = 6'b000001;
        end else begin
            pend.push_back(b);
            if (pend.size() == 5) begin
                if (bz || !(pend[0] == 8'h80 || pend[0] == 8'h81 || pend[0] == 8'hC1)) p = 6'b000001;
                else begin
                    p = 6'b100000;
                    if (pend[0] == 8'h80) m_div = {pend[2], pend[3], pend[4]};
                    if (pend[0] == 8'h81) begin m_rd = {pend[1], pend[2]}; m_dl = {pend[3], pend[4]}; end
                    if (pend[0] == 8'hC1) begin m_fm = pend[3]; m_rm = pend[4]; end
                end
                pend.delete();
            end
        end
        if (p != 0) begin
            x.due = e; x.p = p; x.div = m_div; x.rd = m_rd; x.dl = m_dl; x.rm = m_rm; x.fm = m_fm;
            sb.push_back(x);
        end
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1;
        model(b, busy, cyc + 1);
        @(posedge clk);
        #1 rx_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send5(input logic [7:0] a, b, c, d, e);
        send(a); send(b); send(c); send(d); send(e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        ext_reset_n = 0;
        rx_valid = 0;
        pend.delete();
        m_div = 0; m_rd = 0; m_dl = 0; m_rm = 0; m_fm = 0;
        #2;
        tests++;
        if ({sample_div, read_count, delay_count, trig_rise_mask, trig_fall_mask, cfg_update,
             arm_pulse, soft_reset_pulse, id_req, meta_req, cmd_error} !== '0) begin
            fails++;
            $display("FAIL reset_defaults: got div=%h rd=%h dl=%h rm=%h fm=%h pulses=%b, need all zero",
                     sample_div, read_count, delay_count, trig_rise_mask, trig_fall_mask,
                     {cfg_update, arm_pulse, soft_reset_pulse, id_req, meta_req, cmd_error});
        end
        @(negedge clk);
        @(negedge clk);
        ext_reset_n = 1;
    endtask

    logic [5:0] mon_p;
    exp_t       mon_x;
    always @(negedge clk) if (ext_reset_n) begin
        mon_p = {cfg_update, arm_pulse, soft_reset_pulse, id_req, meta_req, cmd_error};
        if (mon_p != 0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: cycle %0d got pulses=%b, need none", cyc, mon_p);
            end else begin
                mon_x = sb.pop_front();
                if (mon_x.due != cyc || mon_x.p != mon_p || mon_x.div != sample_div ||
                    mon_x.rd != read_count || mon_x.dl != delay_count ||
                    mon_x.rm != trig_rise_mask || mon_x.fm != trig_fall_mask) begin
                    fails++;
                    $display("FAIL event: cyc=%0d p=%b div=%h rd=%h dl=%h rm=%h fm=%h, need cyc=%0d p=%b div=%h rd=%h dl=%h rm=%h fm=%h",
                             cyc, mon_p, sample_div, read_count, delay_count, trig_rise_mask, trig_fall_mask,
                             mon_x.due, mon_x.p, mon_x.div, mon_x.rd, mon_x.dl, mon_x.rm, mon_x.fm);
                end
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_pulse: cycle %0d got none, need pulses=%b at cycle %0d",
                     cyc, sb[0].p, sb[0].due);
            void'(sb.pop_front());
        end
    end

    initial begin
        int r, k;
        logic [7:0] op;
        // T1 reset and back-to-back soft resets
        reset_dut();
        idle(2);
        repeat (5) send(8'h00);
        idle(2);
        // T2 config writes
        send5(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
        send5(8'h81, 8'h3E, 8'h80, 8'h00, 8'hFF);
        send5(8'hC1, 8'h00, 8'h00, 8'h00, 8'h01);
        idle(2);
        // T3 short commands
        send(8'h04); send(8'h02); send(8'h01);
        busy = 1; send(8'h01); busy = 0;
        send(8'h55);
        idle(2);
        // T4 busy interlock
        busy = 1; send5(8'h80, 8'h00, 8'h12, 8'h34, 8'h56);
        busy = 0; send5(8'h80, 8'h00, 8'h12, 8'h34, 8'h56);
        busy = 1; send(8'h00); send(8'h02); send(8'h04); busy = 0;
        idle(2);
        // T5 timeout: dropped partial, then a byte landing exactly on the expiry cycle
        send(8'h81); send(8'hAA); idle(TO); send(8'h01);
        send(8'h81); idle(TO - 1); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        idle(2);
        // T6 resync and unknown long opcode
        send(8'h80); repeat (5) send(8'h00);
        send5(8'h9F, 8'h11, 8'h22, 8'h33, 8'h44);
        // reset in the middle of a command loses it silently
        send(8'hC1); send(8'h11);
        reset_dut();
        send5(8'hC1, 8'h00, 8'h00, 8'hA5, 8'h5A);
        idle(3);
        // randomized traffic
        repeat (250) begin
            r = $urandom_range(0, 9);
            busy = $urandom_range(0, 3) == 0;
            if (r <= 3) begin
                k = $urandom_range(0, 4);
                op = k == 4 ? 8'($urandom_range(0, 127)) : (k == 3 ? 8'h04 : 8'(k));
                send(op);
            end else if (r <= 7) begin
                k = $urandom_range(0, 3);
                op = k == 0 ? 8'h80 : k == 1 ? 8'h81 : k == 2 ? 8'hC1 : 8'($urandom_range(128, 255));
                send(op);
                repeat (4) send(8'($urandom_range(0, 255)));
            end else if (r == 8) begin
                send(8'h80 | 8'($urandom_range(0, 65)));
                repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 255)));
                idle(TO - 1 + $urandom_range(0, 1));
            end else begin
                idle($urandom_range(1, 5));
            end
        end
        busy = 0;
        idle(4);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected events outstanding, need 0", sb.size());
        end
        tests++;
        if (sample_div != m_div || read_count != m_rd || delay_count != m_dl ||
            trig_rise_mask != m_rm || trig_fall_mask != m_fm) begin
            fails++;
            $display("FAIL final_config: got %h %h %h %h %h, need %h %h %h %h %h",
                     sample_div, read_count, delay_count, trig_rise_mask, trig_fall_mask,
                     m_div, m_rd, m_dl, m_rm, m_fm);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
